// File: rtl/shared_counter_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick function for the
// shared_counter_arbiter block.
package shared_counter_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NREQ  = 2;
    localparam int unsigned MAX_NREQ  = 8;

    // Search starts just after last, wraps, and takes the first set request.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          last,
        input int unsigned         n
    );
        logic [MAX_NREQ-1:0] win;
        logic [2:0]          idx;
        logic                found;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx = 3'(({29'd0, last} + k) % n);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shared_counter_arbiter_load_counter.sv
// WIDTH-bit up-counter with synchronous clear/enable and a terminal flag
// that fires when the count reaches the loaded period minus one.
module shared_counter_arbiter_load_counter
    import shared_counter_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_period,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count  <= '0;
            r_period <= '0;
        end else begin
            if (i_clear)
                r_count <= '0;
            else if (i_enable)
                r_count <= r_count + WIDTH'(1);
            if (i_load)
                r_period <= i_period;
        end
    end

    // Modulo compare: a period of zero terminates at all-ones (2^WIDTH cycles).
    assign o_terminal = (r_count == (r_period - WIDTH'(1)));
    assign o_count    = r_count;

endmodule

// File: rtl/shared_counter_arbiter.sv
// Round-robin owner of a shared load counter: grants one requester, runs the
// counter for that requester's period, then pulses done.
module shared_counter_arbiter
    import shared_counter_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] period,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state, w_state_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic [NREQ-1:0]   r_done,  w_done_nxt;
    logic [IW-1:0]     r_owner, w_owner_nxt;
    logic [IW-1:0]     r_last,  w_last_nxt;

    logic [MAX_NREQ-1:0] w_req_ext;
    logic [2:0]          w_last_ext;
    logic [MAX_NREQ-1:0] w_pick;
    logic [IW-1:0]       w_win_idx;
    logic [NREQ-1:0]     w_win_oh;
    logic [WIDTH-1:0]    w_period_win;
    logic                w_clear, w_enable, w_load, w_terminal;
    logic [WIDTH-1:0]    w_count;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[NREQ-1:0]    = req;
        w_last_ext             = '0;
        w_last_ext[IW-1:0]     = r_last;
        w_pick                 = rr_pick(w_req_ext, w_last_ext, NREQ);
        w_win_idx              = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++)
            if (w_pick[i]) w_win_idx = i[IW-1:0];
        w_win_oh               = '0;
        w_win_oh[w_win_idx]    = 1'b1;
        w_period_win           = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (w_win_idx == i[IW-1:0]) w_period_win = period[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = RUN;
                    w_grant_nxt = w_win_oh;
                    w_owner_nxt = w_win_idx;
                    w_load      = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                // Abort outranks terminal: a dropped request never sees done.
                if (!req[r_owner]) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_owner;
                    w_clear     = 1'b1;
                end else if (w_terminal) begin
                    w_state_nxt         = IDLE;
                    w_grant_nxt         = '0;
                    w_done_nxt[r_owner] = 1'b1;
                    w_last_nxt          = r_owner;
                    w_clear             = 1'b1;
                end else begin
                    w_enable = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    shared_counter_arbiter_load_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_load     (w_load),
        .i_period   (w_period_win),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = (r_state == RUN);
    assign count = w_count;

endmodule

// File: doc/shared_counter_arbiter.md
Name: shared_counter_arbiter

Overview:
- Controller that shares one free-running-style up-counter core between NREQ requesters.
- Requesters raise a level request with a programmed period. The block arbitrates round-robin and grants the counter to one winner. It then runs the counter for exactly that period and returns a one-cycle done pulse.
- Sits between software/timer clients and the counter datapath as the single owner of its load/enable controls.

Parameters:
- WIDTH, 4, counter and period width in bits.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- req, input, NREQ, level request per requester; must stay high until done or it aborts.
- period, input, NREQ*WIDTH, packed per-requester period; slice i = period[i*WIDTH +: WIDTH]; sampled only at grant.
- grant, output, NREQ, one-hot (or zero) ownership of the counter.
- done, output, NREQ, one-cycle completion pulse to the owning requester.
- busy, output, 1, high while in RUN.
- count, output, WIDTH, current counter value.

Behaviour:
- Reset state (asynchronous, immediate): state=IDLE, grant=0, done=0, busy=0, count=0, rr pointer set so requester 0 has highest priority.
- States: IDLE, RUN.

IDLE:
- done from a previous RUN may be high for this one cycle only.
- If any req bit is high, select a winner round-robin: search starts at last_owner+1, wraps, lowest index first. The following happens at the next edge:
  - state→RUN
  - grant=onehot(winner), busy=1, count=0
  - period_q=period slice of winner
  - owner=winner
- If no req bit is high: remain in IDLE, count holds 0.

RUN:
- Each edge, count←count+1 (WIDTH-bit wrap).
- Terminal condition: count==period_q−1 (modulo 2^WIDTH). period_q=0 therefore means 2^WIDTH cycles.
- At the edge ending the terminal cycle:
  - done[owner]=1 for one cycle
  - grant=0, busy=0, count=0
  - last_owner=owner
  - state→IDLE
- grant[owner] is high for exactly period_q cycles (2^WIDTH when 0). count shows 0,1,…,period_q−1 during grant.
- Abort: if req[owner] is low in any RUN cycle, the next edge does the following and abort takes priority over terminal:
  - state→IDLE, grant=0, busy=0, count=0
  - no done
  - last_owner=owner
- req bits of non-owners are ignored during RUN; they are not queued, only re-sampled in IDLE.

Timing and protocol rules:
- Minimum gap between consecutive grants is one IDLE cycle. There is no back-to-back grant.
- done and grant never overlap. At most one done bit and at most one grant bit are high at once.
- Requester obligations: drop req in the done cycle to avoid re-request. If req is still high in that IDLE cycle, it counts as a new request, and round-robin favours the others.
- period changes while in RUN have no effect.
- Reset mid-RUN: outputs return to reset values immediately. No done is generated, and the rr pointer returns to requester 0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN)
  - default WIDTH/NREQ values
  - a round-robin pick function: req vector + last_owner → one-hot winner.
- One sub-module is natural: load_counter. It is a WIDTH-bit up-counter with asynchronous active-high rst, synchronous clear and enable, and a terminal-compare output against a loaded period. The controller drives only its clear/enable/load.

Test Plan:
- All tests use WIDTH=4, NREQ=2.
- Reset: assert rst mid-cycle with random inputs → grant=0, done=0, busy=0, count=0 immediately, with no clock needed.
- Single request: req=01, period0=3 → grant=01 for 3 cycles, count 0,1,2, then done=01 for one cycle, grant=00, busy=0.
- Contention from reset: req=11, periods 2 and 5 → req0 granted first (2 cycles), one IDLE cycle with done=01, then req1 granted (5 cycles), then done=10. If req0 is still high after its done, it is granted only after req1 completes.
- Zero period: req=10, period1=0 → grant=10 for 16 cycles, count 0..15 then wraps. done=10 after count=15.
- Abort: req1 granted with period1=9; drop req1 while count=2 → grant=00 at next edge, count=0, no done pulse. A pending req0 is granted after one IDLE cycle.
- Reset mid-RUN: req0 running, count=4, pulse rst → all outputs zero asynchronously, no done. After release with req=11, req0 wins.
